// File: rtl/dcache_pkg.sv
// Shared constants and state encoding for the direct-mapped write-back data cache.
// Default geometry is 16 lines of 4 words, 24-bit tags.
package dcache_pkg;

  localparam int unsigned INDEX_W_DEF  = 4;
  localparam int unsigned OFFSET_W_DEF = 2;
  localparam int unsigned TAG_W        = 32 - 2 - OFFSET_W_DEF - INDEX_W_DEF;
  localparam int unsigned LINE_WORDS   = 1 << OFFSET_W_DEF;
  localparam logic [23:0] UNCACHED_HI  = 24'h000000;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t WB     = 2'd1;
  localparam state_t REFILL = 2'd2;

  // The low 256 bytes are local scratch space that never touches the cache.
  function automatic logic is_uncached(input logic [31:0] a);
    return a[31:8] == UNCACHED_HI;
  endfunction

endpackage

// File: rtl/dcache_store.sv
// Tag/data arrays of the data cache: combinational read, one word write, one metadata write.
// Only valid/dirty are reset; tags and data come up undefined.
module dcache_store
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_W  = INDEX_W_DEF,
  parameter int unsigned OFFSET_W = OFFSET_W_DEF,
  parameter int unsigned TagBits  = TAG_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [INDEX_W-1:0]  rd_idx_i,
  input  logic [OFFSET_W-1:0] rd_off_i,
  output logic                rd_valid_o,
  output logic                rd_dirty_o,
  output logic [TagBits-1:0]  rd_tag_o,
  output logic [31:0]         rd_word_o,
  input  logic                word_we_i,
  input  logic [INDEX_W-1:0]  word_idx_i,
  input  logic [OFFSET_W-1:0] word_off_i,
  input  logic [31:0]         word_data_i,
  input  logic                meta_we_i,
  input  logic [INDEX_W-1:0]  meta_idx_i,
  input  logic [TagBits-1:0]  meta_tag_i,
  input  logic                meta_valid_i,
  input  logic                meta_dirty_i
);

  localparam int unsigned Lines     = 1 << INDEX_W;
  localparam int unsigned LineWords = 1 << OFFSET_W;

  logic [Lines-1:0]   valid_q;
  logic [Lines-1:0]   dirty_q;
  logic [TagBits-1:0] tag_q  [Lines];
  logic [31:0]        data_q [Lines][LineWords];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we_i) begin
      valid_q[meta_idx_i] <= meta_valid_i;
      dirty_q[meta_idx_i] <= meta_dirty_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (meta_we_i) begin
      tag_q[meta_idx_i] <= meta_tag_i;
    end
    if (word_we_i) begin
      data_q[word_idx_i][word_off_i] <= word_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_word_o  = data_q[rd_idx_i][rd_off_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller for the MEM stage.
// Hits complete combinationally; misses write back a dirty victim, refill, then hit.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_W  = INDEX_W_DEF,
  parameter int unsigned OFFSET_W = OFFSET_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r_valid,
  input  logic        w_valid,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic        r_ready,
  output logic        w_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int unsigned TagW = 30 - INDEX_W - OFFSET_W;

  state_t              state_q, state_d;
  logic [OFFSET_W-1:0] beat_q, beat_d;
  logic [TagW-1:0]     victim_tag_q, victim_tag_d;
  logic [TagW-1:0]     req_tag_q, req_tag_d;
  logic [INDEX_W-1:0]  idx_q, idx_d;
  logic                just_filled_q, just_filled_d;
  logic [31:0]         hit_cnt_q, hit_cnt_d;
  logic [31:0]         miss_cnt_q, miss_cnt_d;

  logic [TagW-1:0]     a_tag;
  logic [INDEX_W-1:0]  a_idx;
  logic [OFFSET_W-1:0] a_off;
  logic                uncached, req, in_idle, hit, miss, last_beat;
  logic                unused_addr;

  logic [INDEX_W-1:0]  rd_idx;
  logic [OFFSET_W-1:0] rd_off;
  logic                rd_valid, rd_dirty;
  logic [TagW-1:0]     rd_tag;
  logic [31:0]         rd_word;

  logic                word_we;
  logic [INDEX_W-1:0]  word_idx;
  logic [OFFSET_W-1:0] word_off;
  logic [31:0]         word_data;
  logic                meta_we, meta_valid, meta_dirty;
  logic [INDEX_W-1:0]  meta_idx;
  logic [TagW-1:0]     meta_tag;

  assign a_tag       = addr[31 -: TagW];
  assign a_idx       = addr[2+OFFSET_W +: INDEX_W];
  assign a_off       = addr[2 +: OFFSET_W];
  assign unused_addr = ^addr[1:0];

  assign uncached  = is_uncached(addr);
  assign req       = r_valid | w_valid;
  assign in_idle   = (state_q == IDLE);
  assign last_beat = &beat_q;

  // In IDLE the array is looked up by the request; during a miss by the latched line/beat.
  assign rd_idx = in_idle ? a_idx : idx_q;
  assign rd_off = in_idle ? a_off : beat_q;

  assign hit  = in_idle & req & ~uncached & rd_valid & (rd_tag == a_tag);
  assign miss = in_idle & req & ~uncached & ~hit;

  dcache_store #(
    .INDEX_W  (INDEX_W),
    .OFFSET_W (OFFSET_W),
    .TagBits  (TagW)
  ) u_store (
    .clk_i        (clk),
    .rst_i        (rst),
    .rd_idx_i     (rd_idx),
    .rd_off_i     (rd_off),
    .rd_valid_o   (rd_valid),
    .rd_dirty_o   (rd_dirty),
    .rd_tag_o     (rd_tag),
    .rd_word_o    (rd_word),
    .word_we_i    (word_we),
    .word_idx_i   (word_idx),
    .word_off_i   (word_off),
    .word_data_i  (word_data),
    .meta_we_i    (meta_we),
    .meta_idx_i   (meta_idx),
    .meta_tag_i   (meta_tag),
    .meta_valid_i (meta_valid),
    .meta_dirty_i (meta_dirty)
  );

  // Store wins over load when both are presented.
  always_comb begin
    r_ready = 1'b0;
    w_ready = 1'b0;
    r_data  = 32'h0;
    if (uncached && req) begin
      r_ready = 1'b1;
      w_ready = 1'b1;
    end else if (hit) begin
      if (w_valid) begin
        w_ready = 1'b1;
      end else begin
        r_ready = 1'b1;
        r_data  = rd_word;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    victim_tag_d  = victim_tag_q;
    req_tag_d     = req_tag_q;
    idx_d         = idx_q;
    just_filled_d = just_filled_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;

    word_we    = 1'b0;
    word_idx   = idx_q;
    word_off   = beat_q;
    word_data  = mem_rdata;
    meta_we    = 1'b0;
    meta_idx   = idx_q;
    meta_tag   = req_tag_q;
    meta_valid = 1'b1;
    meta_dirty = 1'b0;

    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;

    case (state_q)
      IDLE: begin
        just_filled_d = 1'b0;
        if (hit) begin
          // The hit that retires a just-completed refill was already counted as a miss.
          if (!just_filled_q) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
          end
          if (w_valid) begin
            word_we    = 1'b1;
            word_idx   = a_idx;
            word_off   = a_off;
            word_data  = w_data;
            meta_we    = 1'b1;
            meta_idx   = a_idx;
            meta_tag   = a_tag;
            meta_dirty = 1'b1;
          end
        end else if (miss) begin
          miss_cnt_d   = miss_cnt_q + 32'd1;
          victim_tag_d = rd_tag;
          req_tag_d    = a_tag;
          idx_d        = a_idx;
          beat_d       = '0;
          state_d      = (rd_valid && rd_dirty) ? WB : REFILL;
        end
      end

      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {victim_tag_q, idx_q, beat_q, 2'b00};
        mem_wdata = rd_word;
        if (mem_ack) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = REFILL;
          end else begin
            beat_d = beat_q + OFFSET_W'(1);
          end
        end
      end

      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag_q, idx_q, beat_q, 2'b00};
        if (mem_ack) begin
          word_we = 1'b1;
          if (last_beat) begin
            meta_we       = 1'b1;
            beat_d        = '0;
            state_d       = IDLE;
            just_filled_d = 1'b1;
          end else begin
            beat_d = beat_q + OFFSET_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      victim_tag_q  <= '0;
      req_tag_q     <= '0;
      idx_q         <= '0;
      just_filled_q <= 1'b0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      victim_tag_q  <= victim_tag_d;
      req_tag_q     <= req_tag_d;
      idx_q         <= idx_d;
      just_filled_q <= just_filled_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule
